rng_lfsr_32: RTL and testbench

//   32-bit Galois LFSR pseudo-random source for the random_generator_32 block.

---
 rtl/rng_pkg.sv | 20 ++
 rtl/rng_lfsr_32_if.sv | 24 ++
 rtl/lfsr_core_32.sv | 44 ++++
 rtl/rng_lfsr_32.sv | 114 +++++++++++
 tb/tb_rng_lfsr_32.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// Shared types, defaults and the LFSR step function for the rng_lfsr_32 block.
package rng_pkg;

    localparam int unsigned RNG_W = 32;

    localparam logic [RNG_W-1:0] RNG_TAPS         = 32'h8020_0003;
    localparam logic [RNG_W-1:0] RNG_SEED_DEFAULT = 32'hACE1_2468;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } rng_state_t;

    // One Galois right-shift step: shift down, fold taps in when the bit leaving is 1.
    function automatic logic [RNG_W-1:0] lfsr_step(input logic [RNG_W-1:0] s,
                                                   input logic [RNG_W-1:0] taps);
        return {1'b0, s[RNG_W-1:1]} ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/rng_lfsr_32_if.sv
// Control and output-stream signals of rng_lfsr_32; master = generator, slave = consumer/controller.
interface rng_lfsr_32_if;
    import rng_pkg::*;

    logic             en;
    logic             seed_load;
    logic [RNG_W-1:0] seed_in;
    logic             ent_in;
    logic [RNG_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        input  en, seed_load, seed_in, ent_in, out_ready,
        output out_data, out_valid, busy
    );

    modport slave (
        output en, seed_load, seed_in, ent_in, out_ready,
        input  out_data, out_valid, busy
    );

endinterface

// File: rtl/lfsr_core_32.sv
// 32-bit Galois LFSR state register with seed mux and all-zero lock-up guard.
module lfsr_core_32
    import rng_pkg::*;
#(
    parameter logic [RNG_W-1:0] SEED_DEFAULT = RNG_SEED_DEFAULT,
    parameter logic [RNG_W-1:0] TAPS         = RNG_TAPS
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             step,
    input  logic             load,
    input  logic [RNG_W-1:0] load_val,
    input  logic             mix_bit,
    output logic [RNG_W-1:0] lfsr
);

    localparam logic [RNG_W-1:0] MSB_MASK = {1'b1, {(RNG_W-1){1'b0}}};

    logic [RNG_W-1:0] lfsr_q;
    logic [RNG_W-1:0] lfsr_d;
    logic [RNG_W-1:0] nxt_c;

    // Load wins over step; zero never enters the register from either path.
    always_comb begin
        nxt_c  = lfsr_step(lfsr_q, TAPS) ^ (mix_bit ? MSB_MASK : '0);
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (load_val == '0) ? SEED_DEFAULT : load_val;
        end else if (step) begin
            lfsr_d = (nxt_c == '0) ? SEED_DEFAULT : nxt_c;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/rng_lfsr_32.sv
// Pseudo-random word source: warm-up FSM, seed handling and valid/ready output register.
// Optional feature: define RNG_ENTROPY_MIX_EN to fold ent_in into bit 31 of every step.
module rng_lfsr_32
    import rng_pkg::*;
#(
    parameter logic [RNG_W-1:0] SEED_DEFAULT  = RNG_SEED_DEFAULT,
    parameter logic [RNG_W-1:0] TAPS          = RNG_TAPS,
    parameter int unsigned      WARMUP_CYCLES = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    rng_lfsr_32_if.master rif
);

    localparam int unsigned      CNT_W     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP_CYCLES == 0) ? '0 : CNT_W'(WARMUP_CYCLES - 1);
    localparam rng_state_t       START_ST  = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

    rng_state_t       state_q,     state_d;
    logic [CNT_W-1:0] warm_cnt_q,  warm_cnt_d;
    logic [RNG_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             step_c;
    logic             capture_c;
    logic             mix_bit;
    logic [RNG_W-1:0] lfsr;

`ifdef RNG_ENTROPY_MIX_EN
    assign mix_bit = rif.ent_in;
`else
    logic unused_ent;
    assign unused_ent = rif.ent_in;
    assign mix_bit    = 1'b0;
`endif

    lfsr_core_32 #(
        .SEED_DEFAULT (SEED_DEFAULT),
        .TAPS         (TAPS)
    ) u_core (
        .clk      (clk),
        .clr_n    (clr_n),
        .step     (step_c),
        .load     (rif.seed_load),
        .load_val (rif.seed_in),
        .mix_bit  (mix_bit),
        .lfsr     (lfsr)
    );

    // Next state: seed_load overrides everything, otherwise only enabled cycles advance.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        step_c      = 1'b0;
        capture_c   = 1'b0;

        if (rif.seed_load) begin
            state_d     = START_ST;
            warm_cnt_d  = '0;
            busy_d      = (START_ST == WARMUP);
            out_valid_d = 1'b0;
        end else begin
            if (rif.en) begin
                step_c = 1'b1;
                unique case (state_q)
                    WARMUP: begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d    = RUN;
                            warm_cnt_d = '0;
                            busy_d     = 1'b0;
                        end else begin
                            warm_cnt_d = warm_cnt_q + CNT_W'(1);
                        end
                    end
                    RUN: capture_c = !out_valid_q || rif.out_ready;
                    default: ;
                endcase
            end

            // Capture takes the pre-step LFSR value; otherwise a handshake just drains the word.
            if (capture_c) begin
                out_data_d  = lfsr;
                out_valid_d = 1'b1;
            end else if (out_valid_q && rif.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= START_ST;
            warm_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= (START_ST == WARMUP);
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rif.out_data  = out_data_q;
    assign rif.out_valid = out_valid_q;
    assign rif.busy      = busy_q;

endmodule

// File: tb/tb_rng_lfsr_32.sv
// Self-checking bench for rng_lfsr_32: per-cycle reference model plus directed literal checks.
module tb_rng_lfsr_32;
    import rng_pkg::*;

    localparam int unsigned W    = 2;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef RNG_ENTROPY_MIX_EN
    localparam bit MIX = 1'b1;
    localparam int RAND_CYCLES = 20000;
`else
    localparam bit MIX = 1'b0;
    localparam int RAND_CYCLES = 400;
`endif

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    rng_lfsr_32_if rif ();

    rng_lfsr_32 #(
        .SEED_DEFAULT  (SEED),
        .TAPS          (TAPS),
        .WARMUP_CYCLES (W)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .rif   (rif)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference step written straight from the polynomial description.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic e);
        logic [31:0] n;
        n     = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
        n[31] = n[31] ^ (e & MIX);
        if (n == 32'h0) n = SEED;
        return n;
    endfunction

    // Model: warm-up as a count of remaining steps, output as a one-word buffer.
    logic [31:0] m_lfsr, m_data;
    int unsigned m_left;
    logic        m_valid;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_lfsr  <= SEED;
            m_left  <= W;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
        end else if (rif.seed_load) begin
            m_lfsr  <= (rif.seed_in == 32'h0) ? SEED : rif.seed_in;
            m_left  <= W;
            m_valid <= 1'b0;
        end else if (rif.en) begin
            m_lfsr <= ref_step(m_lfsr, rif.ent_in);
            if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (!m_valid || rif.out_ready) begin
                m_data  <= m_lfsr;
                m_valid <= 1'b1;
            end
        end else if (m_valid && rif.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("cmp_valid", 32'(rif.out_valid), 32'(m_valid));
            check("cmp_data",  rif.out_data, m_data);
            check("cmp_busy",  32'(rif.busy), 32'(m_left != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!rif.out_valid && k < 40) begin
            tick();
            k++;
        end
        check(name, 32'(rif.out_valid), 32'd1);
    endtask

    logic [31:0] saved;
    logic [31:0] exp_next;

    initial begin
        clr_n         = 1'b0;
        rif.en        = 1'b0;
        rif.seed_load = 1'b0;
        rif.seed_in   = 32'h0;
        rif.ent_in    = 1'b0;
        rif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_data",  rif.out_data, 32'h0);
        check("rst_valid", 32'(rif.out_valid), 32'd0);
        check("rst_busy",  32'(rif.busy), 32'd1);
        clr_n  = 1'b1;
        chk_on = 1'b1;

        // Seed 1 with two warm-up steps
        rif.en = 1'b1; rif.out_ready = 1'b1;
        rif.seed_load = 1'b1; rif.seed_in = 32'h1;
        tick();
        rif.seed_load = 1'b0;
        check("seed1_busy", 32'(rif.busy), 32'd1);
        wait_valid("seed1_wait");
        check("seed1_w0", rif.out_data, 32'hC030_0002);
        tick();
        check("seed1_w1", rif.out_data, 32'h6018_0001);

        // Zero seed behaves as the default seed
        rif.seed_load = 1'b1; rif.seed_in = 32'h0;
        tick();
        rif.seed_load = 1'b0;
        wait_valid("seed0_wait");
        check("seed0_w0", rif.out_data, 32'h2B38_491A);
        tick();
        check("seed0_w1", rif.out_data, 32'h159C_248D);
        repeat (3) tick();

        // Consumer stall for 10 cycles
        saved = m_data;
        rif.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_data",  rif.out_data, saved);
            check("stall_valid", 32'(rif.out_valid), 32'd1);
        end
        exp_next = m_lfsr;
        rif.out_ready = 1'b1;
        tick();
        check("stall_release", rif.out_data, exp_next);

        // Enable low for 5 cycles: everything frozen, sequence resumes without a gap
        repeat (2) tick();
        saved = m_data;
        rif.en = 1'b0; rif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("freeze_data",  rif.out_data, saved);
            check("freeze_valid", 32'(rif.out_valid), 32'd1);
        end
        rif.en = 1'b1; rif.out_ready = 1'b1;
        tick();
        check("resume_seq", rif.out_data, ref_step(saved, 1'b0));

        // Consumption with no capture possible drops valid
        rif.en = 1'b0;
        tick();
        check("consume_valid", 32'(rif.out_valid), 32'd0);
        rif.en = 1'b1;
        tick();
        check("recapture_valid", 32'(rif.out_valid), 32'd1);

        // Re-seed while a word is pending
        rif.seed_load = 1'b1; rif.seed_in = 32'h1234_5678;
        tick();
        rif.seed_load = 1'b0;
        check("reseed_valid", 32'(rif.out_valid), 32'd0);
        check("reseed_busy0", 32'(rif.busy), 32'd1);
        tick();
        check("reseed_busy1", 32'(rif.busy), 32'd1);
        tick();
        check("reseed_busy2", 32'(rif.busy), 32'd0);
        wait_valid("reseed_wait");
        check("reseed_w0", rif.out_data, 32'h048D_159E);

        // Random traffic, the model tracks every cycle
        for (int i = 0; i < RAND_CYCLES; i++) begin
            rif.en        = ($urandom_range(0, 9) < 7);
            rif.out_ready = 1'($urandom_range(0, 1));
            rif.ent_in    = 1'($urandom_range(0, 1));
            rif.seed_load = ($urandom_range(0, 49) == 0);
            rif.seed_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            tick();
            if (MIX && rif.out_valid) check("mix_nonzero", 32'(rif.out_data != 32'h0), 32'd1);
        end
        rif.seed_load = 1'b0;
        rif.ent_in    = 1'b0;

        // Asynchronous reset in the middle of operation
        rif.en = 1'b1; rif.out_ready = 1'b1;
        repeat (4) tick();
        clr_n = 1'b0;
        #1;
        check("amid_data",  rif.out_data, 32'h0);
        check("amid_valid", 32'(rif.out_valid), 32'd0);
        check("amid_busy",  32'(rif.busy), 32'd1);
        repeat (2) tick();
        clr_n = 1'b1;
        wait_valid("post_rst_wait");
        check("post_rst_w0", rif.out_data, 32'h2B38_491A);
        repeat (3) tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
